// File: rtl/iiitb_alu_pkg.sv
// Shared types and default widths for the ALU arbiter and related shared-resource blocks.
package iiitb_alu_pkg;

   localparam int ALU_DW  = 8;
   localparam int ALU_OPW = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/iiitb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module iiitb_rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [IW-1:0] cand;

   // Scan offsets from farthest to nearest so the closest hit to ptr wins.
   always_comb begin
      idx  = '0;
      cand = '0;
      any  = |req;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IW'((int'(ptr) + k) % NREQ);
         if (req[cand]) begin
            idx = cand;
         end
      end
      gnt = any ? (NREQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/iiitb_alu_arbiter.sv
// Round-robin arbiter sharing one clocked ALU between NREQ requesters, one operation in flight.
module iiitb_alu_arbiter
   import iiitb_alu_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = ALU_DW,
   parameter int OPW     = ALU_OPW,
   parameter int ALU_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*DW-1:0]  req_a,
   input  logic [NREQ*DW-1:0]  req_b,
   input  logic [NREQ*OPW-1:0] req_op,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [DW-1:0]       rsp_r,
   output logic [DW-1:0]       alu_a,
   output logic [DW-1:0]       alu_b,
   output logic [OPW-1:0]      alu_op,
   input  logic [DW-1:0]       alu_r
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(ALU_LAT + 1);

   arb_state_t     state_reg, state_next;
   logic [IW-1:0]  ptr_reg, ptr_next;
   logic [IW-1:0]  gnt_reg;
   logic [CW-1:0]  cnt_reg, cnt_next;

   logic [NREQ-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            grant_fire;
   logic            capture;

   logic [DW-1:0]   sel_a, sel_b;
   logic [OPW-1:0]  sel_op;

   iiitb_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req (req_valid),
      .ptr (ptr_reg),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == IW'(i)) begin
            sel_a  = req_a[i*DW +: DW];
            sel_b  = req_b[i*DW +: DW];
            sel_op = req_op[i*OPW +: OPW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      req_ready  = '0;
      rsp_valid  = '0;
      grant_fire = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = pick_gnt;
            if (pick_any) begin
               grant_fire = 1'b1;
               cnt_next   = CW'(ALU_LAT);
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt_reg == '0) begin
               capture    = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         RESP: begin
            rsp_valid = NREQ'(1) << gnt_reg;
            // Only the granted requester's ready bit can retire the response.
            if (rsp_ready[gnt_reg]) begin
               ptr_next   = (gnt_reg == IW'(NREQ - 1)) ? '0 : gnt_reg + IW'(1);
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
         cnt_reg <= '0;
         gnt_reg <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_op  <= '0;
         rsp_r   <= '0;
      end else begin
         ptr_reg <= ptr_next;
         cnt_reg <= cnt_next;
         if (grant_fire) begin
            gnt_reg <= pick_idx;
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            alu_op  <= sel_op;
         end
         if (capture) begin
            rsp_r <= alu_r;
         end
      end
   end

endmodule

// File: tb/tb_iiitb_alu_arbiter.sv
// Directed bench for iiitb_alu_arbiter with an R = A + B + op ALU stub and a response scoreboard.
module tb_iiitb_alu_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int OPW  = 3;

   logic                clk;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*DW-1:0]  req_a;
   logic [NREQ*DW-1:0]  req_b;
   logic [NREQ*OPW-1:0] req_op;
   logic [NREQ-1:0]     rsp_valid;
   logic [NREQ-1:0]     rsp_ready;
   logic [DW-1:0]       rsp_r;
   logic [DW-1:0]       alu_a;
   logic [DW-1:0]       alu_b;
   logic [OPW-1:0]      alu_op;
   logic [DW-1:0]       alu_r = '0;

   typedef struct {
      int         idx;
      logic [7:0] r;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   iiitb_alu_arbiter #(
      .NREQ    (NREQ),
      .DW      (DW),
      .OPW     (OPW),
      .ALU_LAT (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_r     (rsp_r),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_r     (alu_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stub: one registered stage.
   always @(posedge clk) alu_r <= alu_a + alu_b + {5'b0, alu_op};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_opnd(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      req_a[i*DW +: DW]    = a;
      req_b[i*DW +: DW]    = b;
      req_op[i*OPW +: OPW] = op;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   // One full operation with rsp_ready high: grant this cycle, response accepted 3 cycles later.
   task automatic serve(input int who, input logic [3:0] valid, input logic [7:0] exp_r);
      req_valid = valid;
      #1;
      check("grant", 32'(req_ready), 32'(1) << who);
      sb_q.push_back('{idx: who, r: exp_r});
      $display("grant req=%0d exp=%02h", who, exp_r);
      cyc();
      req_valid[who] = 1'b0;
      check("ready_low_wait", 32'(req_ready), 32'd0);
      cyc();
      cyc();
      cyc();
   endtask

   // Monitor: pops the scoreboard whenever a response is accepted.
   always @(negedge clk) begin
      if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=%b r=%02h required no response", rsp_valid, rsp_r);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("rsp req=%0d r=%02h", e.idx, rsp_r);
            check("rsp_idx", 32'(rsp_valid), 32'(1) << e.idx);
            check("rsp_r", 32'(rsp_r), 32'(e.r));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      for (int i = 0; i < NREQ; i++) set_opnd(i, 8'h6A, 8'h3B, 3'(i));
      #3;
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_r", 32'(rsp_r), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      check("rst_alu_b", 32'(alu_b), 0);
      check("rst_alu_op", 32'(alu_op), 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Single request with latency checks.
      req_valid = 4'b0001;
      #1;
      check("t1_ready_same_cycle", 32'(req_ready), 32'h1);
      sb_q.push_back('{idx: 0, r: 8'hA5});
      cyc();
      req_valid = '0;
      check("t1_alu_a", 32'(alu_a), 32'h6A);
      check("t1_alu_b", 32'(alu_b), 32'h3B);
      check("t1_alu_op", 32'(alu_op), 0);
      check("t1_rsp_t1", 32'(rsp_valid), 0);
      cyc();
      check("t1_rsp_t2", 32'(rsp_valid), 0);
      cyc();
      check("t1_rsp_t3", 32'(rsp_valid), 32'h1);
      check("t1_rsp_r", 32'(rsp_r), 32'hA5);
      cyc();
      check("t1_idle_rsp", 32'(rsp_valid), 0);
      check("t1_idle_ready", 32'(req_ready), 0);

      // All four requesting from reset: grants 0,1,2,3 four cycles apart.
      do_reset();
      serve(0, 4'b1111, 8'hA5);
      serve(1, 4'b1110, 8'hA6);
      serve(2, 4'b1100, 8'hA7);
      serve(3, 4'b1000, 8'hA8);

      // Round-robin wrap: serve 2 (ptr -> 3), then 3 beats 1; ptr ends at 2.
      set_opnd(3, 8'hF0, 8'h20, 3'd5);
      serve(2, 4'b0100, 8'hA7);
      serve(3, 4'b1010, 8'h15);
      serve(1, 4'b0010, 8'hA6);
      serve(2, 4'b0101, 8'hA7);
      serve(0, 4'b0001, 8'hA5);

      // Backpressure on requester 0 while requester 1 waits.
      rsp_ready = 4'b1110;
      req_valid = 4'b0001;
      #1;
      check("bp_grant0", 32'(req_ready), 32'h1);
      sb_q.push_back('{idx: 0, r: 8'hA5});
      cyc();
      req_valid = 4'b0010;
      cyc();
      cyc();
      for (int k = 0; k < 5; k++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
         check("bp_rsp_r", 32'(rsp_r), 32'hA5);
         check("bp_ready_held", 32'(req_ready), 0);
         cyc();
      end
      rsp_ready = 4'b1111;
      #1;
      check("bp_no_grant_on_accept", 32'(req_ready), 0);
      cyc();
      check("bp_grant1", 32'(req_ready), 32'h2);
      sb_q.push_back('{idx: 1, r: 8'hA6});
      cyc();
      req_valid = '0;
      cyc();
      cyc();
      cyc();

      // Reset during WAIT.
      req_valid = 4'b0001;
      #1;
      check("mr_grant", 32'(req_ready), 32'h1);
      cyc();
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_req_ready", 32'(req_ready), 0);
      check("mr_rsp_valid", 32'(rsp_valid), 0);
      check("mr_rsp_r", 32'(rsp_r), 0);
      check("mr_alu_a", 32'(alu_a), 0);
      check("mr_alu_b", 32'(alu_b), 0);
      check("mr_alu_op", 32'(alu_op), 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         check("mr_no_rsp", 32'(rsp_valid), 0);
      end

      // Idle hold after one operation.
      serve(0, 4'b0001, 8'hA5);
      for (int k = 0; k < 10; k++) begin
         check("idle_ready", 32'(req_ready), 0);
         check("idle_alu_a", 32'(alu_a), 32'h6A);
         check("idle_alu_b", 32'(alu_b), 32'h3B);
         check("idle_alu_op", 32'(alu_op), 0);
         check("idle_rsp_r", 32'(rsp_r), 32'hA5);
         cyc();
      end

      cyc();
      check("sb_drained", 32'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iiitb_alu_arbiter.md
# iiitb_alu_arbiter

Round-robin arbiter that shares one clocked 8-bit ALU (inputs A, B, op[2:0]; registered result R) between NREQ requesters. Each requester sends an operand/opcode request over a valid/ready handshake and receives its result over a valid/ready response channel. One operation is in flight at a time. The block sits between the requesting units and the single ALU instance and drives every ALU input.

## Interface
- NREQ, 4: number of requesters (2..8).
- DW, 8: operand/result width; matches the ALU.
- OPW, 3: opcode width; matches the ALU.
- ALU_LAT, 1: ALU clock edges from operand sample to valid R (≥1).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  requester i has a request pending.
- req_ready  out  NREQ  one-hot grant; the handshake completes when req_valid[i] & req_ready[i].
- req_a  in  NREQ*DW  operand A; requester i uses [i*DW +: DW].
- req_b  in  NREQ*DW  operand B, same packing.
- req_op  in  NREQ*OPW  opcode; requester i uses [i*OPW +: OPW].
- rsp_valid  out  NREQ  one-hot; result available for requester i.
- rsp_ready  in  NREQ  requester i accepts the result.
- rsp_r  out  DW  result, shared by all requesters and qualified by rsp_valid.
- alu_a, alu_b  out  DW  to ALU A/B.
- alu_op  out  OPW  to ALU op.
- alu_r  in  DW  from ALU R.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - Winner selection: the first i with req_valid[i] set, searching upward from ptr with wrap modulo NREQ.
  - req_ready[winner] is driven high combinationally in the same cycle. All other req_ready bits are 0.
  - req_ready is 0 in every state other than IDLE.
  - On the handshake edge: latch req_a/req_b/req_op[winner] into alu_a/alu_b/alu_op; record gnt = winner; load cnt = ALU_LAT; go to WAIT.
  - If no req_valid bit is set, stay in IDLE and hold all outputs.
- **WAIT**
  - alu_a/alu_b/alu_op stay stable.
  - cnt decrements each cycle.
  - When cnt == 0: capture alu_r into rsp_r and go to RESP.
  - WAIT therefore lasts ALU_LAT+1 cycles.
- **RESP**
  - rsp_valid[gnt] = 1 and is held until rsp_ready[gnt].
  - On the accepting edge: ptr = (gnt+1) mod NREQ; go to IDLE.
  - rsp_ready bits other than gnt are ignored.
- alu_a/alu_b/alu_op/rsp_r keep their last values between operations. They change only at a grant edge or a capture edge.
- Requester-side rules:
  - A requester that drops req_valid before it is granted loses nothing; no request state is held for it.
  - A requester must keep req_valid and its operands stable until granted. The arbiter samples them only at the grant edge.
- Fairness: a continuously requesting requester waits at most NREQ-1 other operations.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_r = 0, alu_a = 0, alu_b = 0, alu_op = 0, ptr = 0, cnt = 0, state = IDLE.
- Latency: handshake in cycle t; rsp_valid is high from cycle t+ALU_LAT+2. With ALU_LAT = 1 this is cycle t+3.
- Throughput: with rsp_ready tied high, one operation every ALU_LAT+3 cycles.
- A new request can be granted in the cycle right after the response is accepted. No grant happens in the same cycle as a response acceptance.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by the round-robin order.
- Wrap-around: when gnt = NREQ-1, ptr becomes 0.
- Reset asserted mid-operation: the in-flight operation is discarded and every register returns to its reset value immediately (asynchronous). No response is produced for the lost operation.
- Deassertion of rst_n is synchronised by the integrating block. This block makes no deassertion guarantee.

## Structure
- Shared package iiitb_alu_pkg holds:
  - the FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - the default constants ALU_DW = 8 and ALU_OPW = 3.
- Sub-module iiitb_rr_pick is a pure combinational round-robin priority picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: one-hot grant, binary index, any.
  - It is reused by later shared-resource arbiters.
- The ALU itself is instantiated outside this block.

## Test plan
The bench uses an ALU stub that registers R = A + B + op on each edge, with ALU_LAT = 1.

- **Single request:** reset, then req_valid[0] with A = 8'h6A, B = 8'h3B, op = 0.
  - req_ready[0] is high in the same cycle.
  - rsp_valid[0] goes high 3 cycles later with rsp_r = 8'hA5.
  - After rsp_ready, all signals are idle.
- **All four requesting from reset:** op = i for requester i.
  - Grants occur in order 0, 1, 2, 3, each 4 cycles apart.
  - Results are 8'hA5, 8'hA6, 8'hA7, 8'hA8.
- **Round-robin wrap:**
  - With ptr = 3 after serving requester 2, requesters 1 and 3 request.
  - Requester 3 is granted first, then requester 1.
  - ptr ends at 2.
- **Response backpressure:** hold rsp_ready[0] low for 5 cycles.
  - rsp_valid[0] and rsp_r stay constant throughout.
  - req_ready stays 0 for the waiting requester 1.
  - Requester 1 is granted the cycle after acceptance.
- **Reset mid-operation:** assert rst_n = 0 during WAIT.
  - All outputs are 0 asynchronously.
  - After release, no rsp_valid appears for the aborted request.
- **Idle hold:** no req_valid for 10 cycles.
  - alu_a/alu_b/alu_op/rsp_r keep their last values.
  - req_ready stays 0 (no spurious grants).
